uart_rx_fifo: RTL and testbench

Receive buffer between `uart_rx` and the APB read path of the UART peripheral.
- Accepts frames from `uart_rx` over its valid/ready handshake and stores each data byte together with its frame-error flag.
- Presents the oldest entry first-word-fall-through to the APB read logic.
- Provides occupancy, a watermark interrupt and a sticky overflow flag, so the bus side can drain bursts without losing characters.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_fifo_ram.sv | 34 +++
 rtl/uart_rx_fifo.sv | 107 ++++++++++
 tb/tb_uart_rx_fifo.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the receive-FIFO entry layout.
//   UART_DATA_WIDTH : default payload bits per frame
//   UART_RX_DEPTH   : default receive FIFO depth
//   uart_rx_entry_t : {err, data} as stored in the receive FIFO
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;
  localparam int unsigned UART_RX_DEPTH   = 16;

  typedef struct packed {
    logic                       err;
    logic [UART_DATA_WIDTH-1:0] data;
  } uart_rx_entry_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_ram.sv
// Register-array storage for the UART receive FIFO.
//   CLK   : clock
//   we    : write enable, writes wdata at waddr on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : mem[raddr]
// Contents are deliberately not reset.
module uart_fifo_ram #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WIDTH  = 9,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Single synchronous write port
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read port gives first-word-fall-through at the top level
  assign rdata = mem[raddr];

endmodule : uart_fifo_ram

// File: rtl/uart_rx_fifo.sv
// Receive buffer between uart_rx and the APB read path.
//   CLK, RSTN          : clock, synchronous active-low reset
//   rx_data_i/err_i    : frame from uart_rx and its error tag
//   rx_valid_i/ready_o : push handshake (ready = not full)
//   pop_i              : removes the head entry
//   rd_data_o/rd_err_o : head entry, zero when empty
//   empty_o/full_o     : occupancy flags
//   count_o            : occupancy 0..DEPTH
//   threshold_i/irq_o  : watermark interrupt, threshold 0 disables
//   overflow_o         : sticky, frame offered while full
//   clr_i              : flush entries and clear overflow
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH      = UART_RX_DEPTH,
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  rx_err_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_err_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [CNT_W-1:0]      count_o,
  input  logic [CNT_W-1:0]      threshold_i,
  output logic                  irq_o,
  output logic                  overflow_o,
  input  logic                  clr_i
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned ENTRY_W = DATA_WIDTH + 1;

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               overflow;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] ram_rdata;

  // Flags decode straight from the count register, so they all move together
  assign empty_o    = (count == '0);
  assign full_o     = (count == CNT_W'(DEPTH));
  assign rx_ready_o = !full_o;
  assign count_o    = count;
  assign overflow_o = overflow;

  assign push = rx_valid_i && rx_ready_o && !clr_i;
  assign pop  = pop_i && !empty_o && !clr_i;

  // Watermark follows the count with no extra cycle
  assign irq_o = (threshold_i != '0) && (count >= threshold_i);

  // Head view is masked so stale memory never shows while empty
  assign rd_data_o = empty_o ? '0 : ram_rdata[DATA_WIDTH-1:0];
  assign rd_err_o  = !empty_o && ram_rdata[DATA_WIDTH];

  // Pointers, occupancy and sticky overflow; clr outranks push and pop
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (rx_valid_i && full_o) begin
        overflow <= 1'b1;
      end
    end
  end

  uart_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .CLK   (CLK),
    .we    (push && RSTN),
    .waddr (wr_ptr),
    .wdata ({rx_err_i, rx_data_i}),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo with a queue scoreboard.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 5;

  logic             CLK = 1'b0;
  logic             RSTN;
  logic [7:0]       rx_data_i;
  logic             rx_err_i;
  logic             rx_valid_i;
  logic             rx_ready_o;
  logic             pop_i;
  logic [7:0]       rd_data_o;
  logic             rd_err_o;
  logic             empty_o;
  logic             full_o;
  logic [CNT_W-1:0] count_o;
  logic [CNT_W-1:0] threshold_i;
  logic             irq_o;
  logic             overflow_o;
  logic             clr_i;

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(8), .CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .rx_data_i  (rx_data_i),
    .rx_err_i   (rx_err_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .pop_i      (pop_i),
    .rd_data_o  (rd_data_o),
    .rd_err_o   (rd_err_o),
    .empty_o    (empty_o),
    .full_o     (full_o),
    .count_o    (count_o),
    .threshold_i(threshold_i),
    .irq_o      (irq_o),
    .overflow_o (overflow_o),
    .clr_i      (clr_i)
  );

  always #5 CLK = ~CLK;

  uart_rx_entry_t q[$];
  logic           ovf_m;
  int             n_cmp = 0;
  int             n_bad = 0;

  // One clock with the given inputs; scoreboard tracks what the FIFO must accept
  task automatic step(input logic v, input logic [7:0] d, input logic e,
                      input logic p, input logic c);
    int pre;
    uart_rx_entry_t ent;
    pre        = q.size();
    rx_valid_i = v;
    rx_data_i  = d;
    rx_err_i   = e;
    pop_i      = p;
    clr_i      = c;
    @(posedge CLK);
    if (c) begin
      q.delete();
      ovf_m = 1'b0;
    end else begin
      if (p && pre > 0) void'(q.pop_front());
      if (v && pre < int'(DEPTH)) begin
        ent.err  = e;
        ent.data = d;
        q.push_back(ent);
      end
      if (v && pre == int'(DEPTH)) ovf_m = 1'b1;
    end
    #1;
    rx_valid_i = 1'b0;
    pop_i      = 1'b0;
    clr_i      = 1'b0;
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RSTN = 1'b1;
    @(posedge CLK); #1;
    n_cmp++; if (count_o !== '0)      begin n_bad++; $display("FAIL reset_count: got %0d want 0", count_o); end
    n_cmp++; if (empty_o !== 1'b1)    begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty_o); end
    n_cmp++; if (full_o !== 1'b0)     begin n_bad++; $display("FAIL reset_full: got %b want 0", full_o); end
    n_cmp++; if (rx_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", rx_ready_o); end
    n_cmp++; if (rd_data_o !== 8'h00 || rd_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_rd: got %h/%b want 00/0", rd_data_o, rd_err_o); end
    n_cmp++; if (overflow_o !== 1'b0 || irq_o !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got ovf=%b irq=%b want 0/0", overflow_o, irq_o); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), (i == 5), 1'b0, 1'b0);
      n_cmp++; if (count_o !== CNT_W'(q.size())) begin n_bad++; $display("FAIL fill_count: got %0d want %0d", count_o, q.size()); end
    end
    n_cmp++; if (full_o !== 1'b1 || rx_ready_o !== 1'b0) begin n_bad++; $display("FAIL fill_full: got full=%b ready=%b want 1/0", full_o, rx_ready_o); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (rd_data_o !== q[0].data || rd_err_o !== q[0].err) begin
        n_bad++; $display("FAIL drain_head: got %h/%b want %h/%b", rd_data_o, rd_err_o, q[0].data, q[0].err);
      end
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    n_cmp++; if (empty_o !== 1'b1 || rd_data_o !== 8'h00) begin n_bad++; $display("FAIL drain_empty: got empty=%b data=%h want 1/00", empty_o, rd_data_o); end
  endtask

  task automatic test_overflow_clear();
    for (int i = 0; i < 16; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
    n_cmp++; if (overflow_o !== 1'b0) begin n_bad++; $display("FAIL ovf_early: got %b want 0", overflow_o); end
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (overflow_o !== ovf_m) begin n_bad++; $display("FAIL ovf_set: got %b want %b", overflow_o, ovf_m); end
    n_cmp++; if (count_o !== 5'd16 || rx_ready_o !== 1'b0) begin n_bad++; $display("FAIL ovf_count: got %0d ready=%b want 16/0", count_o, rx_ready_o); end
    n_cmp++; if (rd_data_o !== 8'hA0) begin n_bad++; $display("FAIL ovf_head: got %h want a0", rd_data_o); end
    step(1'b1, 8'h55, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (count_o !== '0 || overflow_o !== 1'b0 || rx_ready_o !== 1'b1 || empty_o !== 1'b1) begin
      n_bad++; $display("FAIL clr: got cnt=%0d ovf=%b ready=%b empty=%b want 0/0/1/1", count_o, overflow_o, rx_ready_o, empty_o);
    end
    // clr drops a push and pop offered on the same edge
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h13, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (count_o !== CNT_W'(q.size()) || empty_o !== 1'b1) begin n_bad++; $display("FAIL clr_prio: got %0d want %0d", count_o, q.size()); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 3; i++) step(1'b1, 8'h31 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h34, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (count_o !== 5'd3) begin n_bad++; $display("FAIL sim3_count: got %0d want 3", count_o); end
    n_cmp++; if (rd_data_o !== 8'h32 || rd_data_o !== q[0].data) begin n_bad++; $display("FAIL sim3_head: got %h want 32", rd_data_o); end
    while (q.size() > 0) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (count_o !== 5'd1) begin n_bad++; $display("FAIL sim0_count: got %0d want 1", count_o); end
    n_cmp++; if (rd_data_o !== 8'h77 || rd_err_o !== 1'b1) begin n_bad++; $display("FAIL sim0_head: got %h/%b want 77/1", rd_data_o, rd_err_o); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (count_o !== 5'd15 || full_o !== 1'b0) begin n_bad++; $display("FAIL sim16_count: got %0d full=%b want 15/0", count_o, full_o); end
    while (q.size() > 0) begin
      n_cmp++;
      if (rd_data_o !== q[0].data || rd_err_o !== q[0].err) begin
        n_bad++; $display("FAIL sim16_drain: got %h/%b want %h/%b", rd_data_o, rd_err_o, q[0].data, q[0].err);
      end
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    n_cmp++; if (empty_o !== 1'b1) begin n_bad++; $display("FAIL sim16_empty: got %b want 1", empty_o); end
  endtask

  task automatic test_wrap();
    int pushed = 0;
    int guard  = 0;
    logic do_pop;
    while ((pushed < 40 || q.size() > 0) && guard < 300) begin
      do_pop = (q.size() > (guard % 6)) || (pushed >= 40);
      if (do_pop && q.size() > 0) begin
        n_cmp++;
        if (rd_data_o !== q[0].data || rd_err_o !== q[0].err) begin
          n_bad++; $display("FAIL wrap_head: got %h/%b want %h/%b", rd_data_o, rd_err_o, q[0].data, q[0].err);
        end
      end
      step(pushed < 40, 8'($urandom), 1'($urandom), do_pop, 1'b0);
      if (pushed < 40) pushed++;
      n_cmp++; if (count_o !== CNT_W'(q.size())) begin n_bad++; $display("FAIL wrap_count: got %0d want %0d", count_o, q.size()); end
      guard++;
    end
    n_cmp++; if (empty_o !== 1'b1 || pushed != 40) begin n_bad++; $display("FAIL wrap_end: got empty=%b pushed=%0d want 1/40", empty_o, pushed); end
  endtask

  task automatic test_watermark();
    logic exp_irq;
    threshold_i = 5'd4;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
      exp_irq = (q.size() >= 4);
      n_cmp++; if (irq_o !== exp_irq) begin n_bad++; $display("FAIL wm_rise: got %b want %b at count %0d", irq_o, exp_irq, q.size()); end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      exp_irq = (q.size() >= 4);
      n_cmp++; if (irq_o !== exp_irq) begin n_bad++; $display("FAIL wm_fall: got %b want %b at count %0d", irq_o, exp_irq, q.size()); end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    threshold_i = 5'd0;
    for (int i = 0; i < 16; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
    n_cmp++; if (irq_o !== 1'b0 || count_o !== 5'd16) begin n_bad++; $display("FAIL wm_zero: got irq=%b cnt=%0d want 0/16", irq_o, count_o); end
    threshold_i = 5'd17;
    #1;
    n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL wm_17: got %b want 0", irq_o); end
    threshold_i = 5'd16;
    #1;
    n_cmp++; if (irq_o !== 1'b1) begin n_bad++; $display("FAIL wm_16_comb: got %b want 1", irq_o); end
    threshold_i = 5'd0;
  endtask

  task automatic test_reset_midway();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b0);
    RSTN       = 1'b0;
    rx_valid_i = 1'b1;
    rx_data_i  = 8'hEE;
    pop_i      = 1'b1;
    @(posedge CLK);
    #1;
    RSTN       = 1'b1;
    rx_valid_i = 1'b0;
    pop_i      = 1'b0;
    q.delete();
    ovf_m = 1'b0;
    n_cmp++; if (count_o !== '0 || empty_o !== 1'b1 || rd_data_o !== 8'h00) begin
      n_bad++; $display("FAIL rst_mid: got cnt=%0d empty=%b data=%h want 0/1/00", count_o, empty_o, rd_data_o);
    end
  endtask

  initial begin
    RSTN        = 1'b0;
    rx_data_i   = '0;
    rx_err_i    = 1'b0;
    rx_valid_i  = 1'b0;
    pop_i       = 1'b0;
    clr_i       = 1'b0;
    threshold_i = '0;
    ovf_m       = 1'b0;
    test_reset();
    test_fill_drain();
    test_overflow_clear();
    test_simultaneous();
    test_wrap();
    test_watermark();
    test_reset_midway();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_uart_rx_fifo
